// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, idle opcode, response entry and FSM state.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  // AND of zero operands never raises Error, so it is safe to drive on idle cycles.
  localparam logic [2:0] IDLE_OP = 3'b010;

  // Widest tag the response FIFO can carry; narrower tags are zero-extended.
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [31:0]          result;
    logic                 error;
    logic [TAG_W_MAX-1:0] tag;
  } rsp_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous first-word-fall-through FIFO of response entries with occupancy count and clear.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  rsp_entry_t wdata,
  input  logic       pop,
  output rsp_entry_t rdata,
  output logic       empty,
  output logic [AW:0] count
);

  rsp_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU command front end: issues one op per cycle, tracks it through the ALU latency and returns
// tagged results in order through a credit-protected FIFO. Define ALU_SEQ_STATS_EN for counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             flush,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic             alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output seq_state_e       dbg_state
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_errors
`endif
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int FW = $clog2(ALU_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             iss_vld_q;
  logic [TAG_W-1:0] iss_tag_q;
  logic             pipe_vld_q [ALU_LAT];
  logic [TAG_W-1:0] pipe_tag_q [ALU_LAT];
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_clear;
  rsp_entry_t       head;
  logic             tail_vld;
  logic             credit_ok;
  logic             accept;
  logic             push;
  logic             pop;
  logic             head_tag_unused;

  // Both streams transfer on a rising edge where valid and ready are high together;
  // cmd_ready is derived from registered state only.
  assign tail_vld  = pipe_vld_q[ALU_LAT-1];
  assign credit_ok = (inflight_q + fifo_count) < CW'(RSP_DEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FLUSH lasts ALU_LAT+1 cycles, enough for the newest issued op to leave the tail.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FW'(ALU_LAT);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - FW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    push       = 1'b0;
    fifo_clear = 1'b0;
    case (state_q)
      ST_RUN: begin
        cmd_ready = !rst && credit_ok;
        rsp_valid = !fifo_empty;
        push      = tail_vld;
      end
      ST_FLUSH: fifo_clear = (flush_cnt_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_q  <= 1'b0;
      iss_tag_q  <= '0;
      inflight_q <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= IDLE_OP;
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= '0;
      end
    end else begin
      iss_vld_q     <= accept;
      iss_tag_q     <= cmd_tag;
      pipe_vld_q[0] <= iss_vld_q;
      pipe_tag_q[0] <= iss_tag_q;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
      // The tail always leaves the pipe, whether it is pushed or discarded by a flush.
      case ({accept, tail_vld})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: ;
      endcase
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
      end else begin
        alu_a      <= '0;
        alu_b      <= '0;
        alu_opcode <= IDLE_OP;
      end
    end
  end

  alu_seq_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (push),
    .wdata ('{result: alu_result, error: alu_error, tag: TAG_W_MAX'(pipe_tag_q[ALU_LAT-1])}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_tag_unused = ^head.tag;
  assign rsp_result      = rsp_valid ? head.result : '0;
  assign rsp_error       = rsp_valid && head.error;
  assign rsp_tag         = rsp_valid ? head.tag[TAG_W-1:0] : '0;
  assign busy            = (inflight_q != '0) || !fifo_empty || (state_q == ST_FLUSH);
  assign dbg_state       = state_q;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_errors_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_errors_q <= '0;
    end else begin
      if (accept)             stat_issued_q <= stat_issued_q + 32'd1;
      if (push && alu_error)  stat_errors_q <= stat_errors_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural registered ALU and an in-order scoreboard.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int ALU_LAT   = 1;
  localparam int RSP_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int EW        = 33 + TAG_W;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [31:0]      cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic             flush;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [2:0]       alu_opcode;
  logic             alu_error;
  logic             rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  seq_state_e       dbg_state;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0]      stat_issued, stat_errors;
  int               n_issued;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;

  alu_op_sequencer #(
    .ALU_LAT(ALU_LAT), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .busy(busy), .dbg_state(dbg_state)
`ifdef ALU_SEQ_STATS_EN
    , .stat_issued(stat_issued), .stat_errors(stat_errors)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'b000:  return {1'b0, a + b};
      3'b001:  return {1'b0, a - b};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {1'b0, a ^ b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // behavioural ALU with registered Result/Error
  logic [32:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_model(alu_a, alu_b, alu_opcode);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_error, alu_result} = alu_pipe[ALU_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: push on command handshake, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
`ifdef ALU_SEQ_STATS_EN
      n_issued = 0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        else chk("rsp", 64'({rsp_error, rsp_result, rsp_tag}), 64'(exp_q.pop_front()));
      end
      if (flush) exp_q.delete();
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back({alu_model(cmd_a, cmd_b, cmd_op), cmd_tag});
`ifdef ALU_SEQ_STATS_EN
        n_issued++;
`endif
      end
    end
  end

  // driver: call just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag);
    logic acc;
    acc = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("send_accept", 64'(acc), 64'(1));
  endtask

  logic [31:0] t3_a [6];
  logic [31:0] t3_b [6];
  logic [2:0]  t3_op [6];
  int          idx;
  int          start;
  logic        acc;

  task automatic load3(input int i);
    cmd_a = t3_a[i]; cmd_b = t3_b[i]; cmd_op = t3_op[i]; cmd_tag = TAG_W'(i);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_op", 64'(alu_opcode), 64'(3'b010));
    chk("rst_rsp", 64'({rsp_valid, rsp_result, rsp_error, rsp_tag}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_RUN));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // single ADD: response three cycles after the accept cycle
    rsp_ready = 1'b1;
    send(32'd5, 32'd7, OP_ADD, 4'd3);
    @(negedge clk);
    chk("t1_alu_a", 64'(alu_a), 64'(5));
    chk("t1_alu_op", 64'(alu_opcode), 64'(OP_ADD));
    chk("t1_lat1", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("t1_idle", 64'({alu_a, alu_b, alu_opcode}), 64'({32'd0, 32'd0, 3'b010}));
    chk("t1_lat2", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("t1_lat3", 64'(rsp_valid), 64'(1));
    chk("t1_result", 64'({rsp_error, rsp_result, rsp_tag}), 64'({1'b0, 32'd12, 4'd3}));
    @(posedge clk); #1;

    // back-to-back SUB / XOR / AND
    send(32'd10, 32'd3, OP_SUB, 4'd1);
    send(32'hF0F0, 32'h0FF0, OP_XOR, 4'd2);
    send(32'hFF, 32'h0F, OP_AND, 4'd4);
    @(negedge clk);
    chk("t2_r0", 64'(rsp_result), 64'(7));
    @(negedge clk);
    chk("t2_r1", 64'(rsp_result), 64'(32'hFF00));
    @(negedge clk);
    chk("t2_r2", 64'(rsp_result), 64'(32'h0F));
    @(negedge clk);
    chk("t2_done", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;

    // credit limit with rsp_ready low
    for (int i = 0; i < 6; i++) begin
      t3_a[i] = $urandom; t3_b[i] = $urandom; t3_op[i] = 3'($urandom_range(0, 4));
    end
    rsp_ready = 1'b0; idx = 0; load3(0); cmd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; if (idx < 6) load3(idx); end
    end
    chk("t3_accepted", 64'(idx), 64'(RSP_DEPTH));
    @(negedge clk);
    chk("t3_ready_low", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; if (idx < 6) load3(idx); end
    end
    cmd_valid = 1'b0;
    chk("t3_all_accepted", 64'(idx), 64'(6));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t3_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;

    // illegal opcode is forwarded and ALU error returned
    send(32'h1234, 32'h5678, 3'b111, 4'd9);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t4_illegal", 64'({rsp_valid, rsp_error, rsp_result, rsp_tag}), 64'({1'b1, 1'b1, 32'd0, 4'd9}));
    @(posedge clk); #1;

    // sustained throughput with rsp_ready high
    start = cyc;
    for (int i = 0; i < 12; i++) send($urandom, $urandom, 3'($urandom_range(0, 7)), 4'($urandom));
    chk("tp_cycles", 64'(cyc - start), 64'(12));
    repeat (6) @(posedge clk); #1;

    // flush with responses queued and one in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 3'($urandom_range(0, 4)), 4'(i + 8));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < ALU_LAT + 1; k++) begin
      @(negedge clk);
      chk("t5_flush_ready", 64'(cmd_ready), 64'(0));
      chk("t5_flush_rsp", 64'(rsp_valid), 64'(0));
      chk("t5_flush_busy", 64'(busy), 64'(1));
    end
    @(negedge clk);
    chk("t5_ready_back", 64'(cmd_ready), 64'(1));
    chk("t5_rsp_cleared", 64'(rsp_valid), 64'(0));
    chk("t5_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;
    send(32'd100, 32'd23, OP_SUB, 4'd5);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t5_only_rsp", 64'({rsp_valid, rsp_result, rsp_tag}), 64'({1'b1, 32'd77, 4'd5}));
    repeat (4) @(negedge clk);
    chk("t5_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;

    // reset with two ops in flight
    send(32'd1, 32'd2, OP_ADD, 4'd6);
    send(32'd3, 32'd4, OP_OR, 4'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp", 64'({rsp_valid, rsp_result, rsp_error, rsp_tag}), 64'(0));
    chk("t6_alu", 64'({alu_a, alu_b, alu_opcode}), 64'({32'd0, 32'd0, 3'b010}));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_ready", 64'(cmd_ready), 64'(1));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(rsp_valid), 64'(0));
    end

`ifdef ALU_SEQ_STATS_EN
    send(32'd9, 32'd9, OP_XOR, 4'd1);
    repeat (4) @(negedge clk);
    chk("stat_issued", 64'(stat_issued), 64'(n_issued));
`endif
    chk("final_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
